apb_cmd_master: RTL and testbench

APB3 initiator that turns a simple command valid/ready request into a single APB transfer (setup phase, then access phase) and returns a response with read data and error status. It drives peripheral-side APB slaves in the subsystem, such as the timer and UART register blocks. It supports slave wait states and slave errors, and aborts a transfer if the slave never responds. Only one transfer is outstanding at a time.

---
 rtl/apb_cmd_master_if.sv | 40 ++++
 rtl/apb_cmd_master.sv | 114 +++++++++++
 tb/tb_apb_cmd_master.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_if.sv
// Bundle of command, response and APB signals for apb_cmd_master.
// The master modport is the initiator's view; slave is the opposite side.
interface apb_cmd_master_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  PSEL;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one valid/ready command becomes one APB transfer, answered
// by one response carrying read data, slave error and timeout status.
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 255
) (
  input logic               PCLK,
  input logic               PRESETn,
  apb_cmd_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] WAIT_MAX  = '1;

  state_t                state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [31:0]           pwdata_q;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;
  logic [CW-1:0]         wait_q;
  logic [CW-1:0]         wait_d;
  logic                  timeout_hit;

  always_comb begin
    wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + CW'(1);
  end

  // Compared against the pre-increment count, so the abort lands on the
  // TIMEOUT-th low-PREADY access cycle.
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            paddr_q   <= {bus.cmd_addr[ADDR_WIDTH-1:2], 2'b00};
            pwrite_q  <= bus.cmd_write;
            pwdata_q  <= bus.cmd_write ? bus.cmd_wdata : 32'd0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          wait_q    <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            rsp_rdata_q   <= (pwrite_q || bus.PSLVERR) ? 32'd0 : bus.PRDATA;
            rsp_err_q     <= bus.PSLVERR;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end else begin
            wait_q <= wait_d;
            if (timeout_hit) begin
              psel_q        <= 1'b0;
              penable_q     <= 1'b0;
              rsp_err_q     <= 1'b1;
              rsp_timeout_q <= 1'b1;
              rsp_rdata_q   <= 32'd0;
              rsp_valid_q   <= 1'b1;
              state_q       <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small wait-state APB slave model.
module tb_apb_cmd_master;

  localparam int AW = 5;

  logic PCLK = 1'b0;
  logic PRESETn;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wait_n   = 0;
  int   acc_cnt  = 0;
  int   en_cyc;

  apb_cmd_master_if #(.ADDR_WIDTH(AW)) bus ();

  apb_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  // Slave holds PREADY low for the first wait_n access cycles
  always @(posedge PCLK) begin
    if (bus.PSEL && bus.PENABLE) acc_cnt <= acc_cnt + 1;
    else                         acc_cnt <= 0;
  end
  assign bus.PREADY = (acc_cnt >= wait_n);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int en);
    en = 0;
    for (int i = 0; i < 40 && !bus.rsp_valid; i++) begin
      if (bus.PENABLE) en++;
      @(negedge PCLK);
    end
    check_eq("rsp_arrived", bus.rsp_valid, 1);
  endtask

  task automatic ret_idle();
    @(negedge PCLK);
    check_eq("rsp_cleared", bus.rsp_valid, 0);
    check_eq("idle_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.PRDATA    = 32'hAAAA5555;
    bus.PSLVERR   = 1'b0;

    @(negedge PCLK);
    check_eq("rst_psel", bus.PSEL, 0);
    check_eq("rst_penable", bus.PENABLE, 0);
    check_eq("rst_pwrite", bus.PWRITE, 0);
    check_eq("rst_paddr", bus.PADDR, 0);
    check_eq("rst_pwdata", bus.PWDATA, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_err", bus.rsp_err, 0);
    check_eq("rst_rsp_timeout", bus.rsp_timeout, 0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 0);
    check_eq("rst_cmd_ready", bus.cmd_ready, 1);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Write, zero wait states, cycle by cycle
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
    bus.cmd_addr  = 5'h08; bus.cmd_wdata = 32'h3;
    check_eq("wr_cmd_ready", bus.cmd_ready, 1);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    check_eq("wr_setup_psel", bus.PSEL, 1);
    check_eq("wr_setup_penable", bus.PENABLE, 0);
    check_eq("wr_setup_paddr", bus.PADDR, 32'h08);
    check_eq("wr_setup_pwrite", bus.PWRITE, 1);
    check_eq("wr_setup_pwdata", bus.PWDATA, 32'h3);
    check_eq("wr_setup_cmd_ready", bus.cmd_ready, 0);
    @(negedge PCLK);
    check_eq("wr_access_psel", bus.PSEL, 1);
    check_eq("wr_access_penable", bus.PENABLE, 1);
    check_eq("wr_access_paddr", bus.PADDR, 32'h08);
    check_eq("wr_access_rsp_valid", bus.rsp_valid, 0);
    @(negedge PCLK);
    check_eq("wr_rsp_valid", bus.rsp_valid, 1);
    check_eq("wr_rsp_err", bus.rsp_err, 0);
    check_eq("wr_rsp_timeout", bus.rsp_timeout, 0);
    check_eq("wr_rsp_rdata", bus.rsp_rdata, 0);
    check_eq("wr_psel_drop", bus.PSEL, 0);
    check_eq("wr_penable_drop", bus.PENABLE, 0);
    check_eq("wr_paddr_hold", bus.PADDR, 32'h08);
    check_eq("wr_pwdata_hold", bus.PWDATA, 32'h3);
    ret_idle();

    // Read with three wait states
    wait_n = 3; bus.PRDATA = 32'h12345678;
    issue(1'b0, 5'h04, 32'hFFFF_FFFF);
    check_eq("rd_pwdata_zero", bus.PWDATA, 0);
    check_eq("rd_pwrite", bus.PWRITE, 0);
    wait_rsp(en_cyc);
    check_eq("rd_penable_cycles", en_cyc, 4);
    check_eq("rd_rsp_rdata", bus.rsp_rdata, 32'h12345678);
    check_eq("rd_rsp_err", bus.rsp_err, 0);
    check_eq("rd_paddr", bus.PADDR, 32'h04);
    ret_idle();

    // Slave error on a misaligned read address
    wait_n = 0; bus.PSLVERR = 1'b1; bus.PRDATA = 32'hDEADBEEF;
    issue(1'b0, 5'h0B, 32'h0);
    wait_rsp(en_cyc);
    check_eq("err_penable_cycles", en_cyc, 1);
    check_eq("err_rsp_err", bus.rsp_err, 1);
    check_eq("err_rsp_timeout", bus.rsp_timeout, 0);
    check_eq("err_rsp_rdata", bus.rsp_rdata, 0);
    check_eq("err_paddr_aligned", bus.PADDR, 32'h08);
    ret_idle();

    // Timeout with PREADY held low; PSLVERR while not ready is ignored
    wait_n = 1000; bus.PSLVERR = 1'b1; bus.PRDATA = 32'h11111111;
    issue(1'b0, 5'h0C, 32'h0);
    wait_rsp(en_cyc);
    check_eq("to_penable_cycles", en_cyc, 8);
    check_eq("to_psel_drop", bus.PSEL, 0);
    check_eq("to_penable_drop", bus.PENABLE, 0);
    check_eq("to_rsp_err", bus.rsp_err, 1);
    check_eq("to_rsp_timeout", bus.rsp_timeout, 1);
    check_eq("to_rsp_rdata", bus.rsp_rdata, 0);
    ret_idle();

    // Normal write after a timeout
    wait_n = 0; bus.PSLVERR = 1'b0; bus.PRDATA = 32'h22222222;
    issue(1'b1, 5'h14, 32'hCAFE0001);
    wait_rsp(en_cyc);
    check_eq("post_to_cycles", en_cyc, 1);
    check_eq("post_to_err", bus.rsp_err, 0);
    check_eq("post_to_timeout", bus.rsp_timeout, 0);
    check_eq("post_to_rdata", bus.rsp_rdata, 0);
    check_eq("post_to_pwdata", bus.PWDATA, 32'hCAFE0001);
    ret_idle();

    // Response backpressure with a second command held valid
    bus.rsp_ready = 1'b0; bus.PRDATA = 32'h0BADF00D;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
    bus.cmd_addr  = 5'h18; bus.cmd_wdata = 32'h0;
    @(negedge PCLK);
    bus.cmd_write = 1'b1; bus.cmd_addr = 5'h10; bus.cmd_wdata = 32'h55;
    @(negedge PCLK);
    @(negedge PCLK);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_rsp_valid", bus.rsp_valid, 1);
      check_eq("bp_rsp_rdata", bus.rsp_rdata, 32'h0BADF00D);
      check_eq("bp_rsp_err", bus.rsp_err, 0);
      check_eq("bp_cmd_ready", bus.cmd_ready, 0);
      check_eq("bp_no_psel", bus.PSEL, 0);
      if (i == 4) bus.rsp_ready = 1'b1;
      @(negedge PCLK);
    end
    check_eq("bp_released", bus.rsp_valid, 0);
    check_eq("bp_ready_again", bus.cmd_ready, 1);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    check_eq("bp_next_psel", bus.PSEL, 1);
    check_eq("bp_next_paddr", bus.PADDR, 32'h10);
    check_eq("bp_next_pwrite", bus.PWRITE, 1);
    check_eq("bp_next_pwdata", bus.PWDATA, 32'h55);
    wait_rsp(en_cyc);
    check_eq("bp_next_err", bus.rsp_err, 0);
    ret_idle();

    // Asynchronous reset during the access phase
    wait_n = 1000;
    issue(1'b0, 5'h04, 32'h0);
    @(negedge PCLK);
    check_eq("rst_mid_penable_pre", bus.PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    check_eq("rst_mid_psel", bus.PSEL, 0);
    check_eq("rst_mid_penable", bus.PENABLE, 0);
    check_eq("rst_mid_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_mid_paddr", bus.PADDR, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    wait_n  = 0;
    check_eq("rst_mid_cmd_ready", bus.cmd_ready, 1);
    @(negedge PCLK);
    check_eq("rst_mid_no_rsp", bus.rsp_valid, 0);
    check_eq("rst_mid_no_psel", bus.PSEL, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
